vend_dispense_ctrl: RTL

Dispense controller that sequences the vending credit FSM and the product motors. Debounces N product-select buttons and latches their rising edges as pending requests. Grants one request at a time, round-robin, and compares the granted product's price against the current credit. Then either drives a fixed-length motor pulse, consumes the credit with a one-cycle accept pulse, and emits change pulses, or signals deny.

---
 rtl/vend_pkg.sv | 25 ++
 rtl/vend_btn_db.sv | 29 ++
 rtl/vend_dispense_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense controller.
package vend_pkg;

   localparam int unsigned CREDIT_W = 2;
   localparam int unsigned DB_DEPTH = 3;
   localparam int unsigned ID_W     = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_VEND   = 3'd2,
      ST_ACCEPT = 3'd3,
      ST_CHG_HI = 3'd4,
      ST_CHG_LO = 3'd5,
      ST_DENY   = 3'd6
   } vend_state_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/vend_btn_db.sv
// Per-button debounce: level is high only after DB_DEPTH consecutive high
// samples; o_rise_c pulses for one cycle on each 0->1 of that level.
module vend_btn_db
   import vend_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_rise_c
);

   logic [DB_DEPTH-1:0] r_sh;
   logic                r_lvl_q;
   logic                w_lvl;

   assign w_lvl    = &r_sh;
   assign o_rise_c = w_lvl & ~r_lvl_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh    <= '0;
         r_lvl_q <= 1'b0;
      end else begin
         r_sh    <= {r_sh[DB_DEPTH-2:0], i_raw};
         r_lvl_q <= w_lvl;
      end
   end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense controller: debounced select requests, round-robin grant, price
// check, motor pulse, accept pulse and change pulse train, or deny.
// Optional macro VEND_STATS_EN builds the 16-bit completed-vend counter.
module vend_dispense_ctrl
   import vend_pkg::*;
#(
   parameter int unsigned           N_PROD    = 4,
   parameter logic [2*N_PROD-1:0]   PRICE     = {2'd3, 2'd2, 2'd2, 2'd1},
   parameter int unsigned           MOTOR_CYC = 1000,
   parameter int unsigned           CHG_CYC   = 100,
   parameter int unsigned           DENY_CYC  = 500
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_PROD-1:0]   sel_raw,
   input  logic [CREDIT_W-1:0] credit,
   output logic                accept,
   output logic [N_PROD-1:0]   motor,
   output logic                change,
   output logic                deny,
   output logic                busy,
   output logic [ID_W-1:0]     grant_id,
   output logic [15:0]         vend_count
);

   localparam int unsigned CNT_MAX = max3(MOTOR_CYC, CHG_CYC, DENY_CYC);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned IDX_W   = (N_PROD > 1) ? $clog2(N_PROD) : 1;

   vend_state_t         r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [CREDIT_W-1:0] r_cr_q;
   logic [CREDIT_W-1:0] r_pr_q;
   logic [CREDIT_W-1:0] r_chg;
   logic [ID_W-1:0]     r_rr;
   logic [ID_W-1:0]     r_grant;
   logic [N_PROD-1:0]   r_pending;
   logic [N_PROD-1:0]   r_motor;
   logic                r_accept;
   logic                r_change;
   logic                r_deny;
   logic                r_busy;

   logic [N_PROD-1:0]   w_rise;
   logic                w_gnt_valid;
   logic [ID_W-1:0]     w_gnt_idx;
   logic [ID_W-1:0]     w_rr_next;
   logic [N_PROD-1:0]   w_clr;
   logic [CREDIT_W-1:0] w_price;
   int unsigned         w_idx;

   for (genvar g = 0; g < N_PROD; g++) begin : g_db
      vend_btn_db u_db (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_raw    (sel_raw[g]),
         .o_rise_c (w_rise[g])
      );
   end

   // Round-robin search: first pending bit at or above r_rr, wrapping.
   always_comb begin
      w_gnt_valid = 1'b0;
      w_gnt_idx   = '0;
      w_idx       = 0;
      for (int unsigned k = 0; k < N_PROD; k++) begin
         w_idx = (32'(r_rr) + k) % N_PROD;
         if (!w_gnt_valid && r_pending[IDX_W'(w_idx)]) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = ID_W'(w_idx);
         end
      end
   end

   always_comb begin
      w_rr_next = (w_gnt_idx == ID_W'(N_PROD - 1)) ? '0 : w_gnt_idx + ID_W'(1);
      w_clr     = '0;
      if (r_state == ST_IDLE && w_gnt_valid) begin
         w_clr = N_PROD'(1) << w_gnt_idx;
      end
   end

   always_comb begin
      w_price = '0;
      for (int unsigned i = 0; i < N_PROD; i++) begin
         if (r_grant == ID_W'(i)) begin
            w_price = PRICE[2*i +: 2];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_cr_q    <= '0;
         r_pr_q    <= '0;
         r_chg     <= '0;
         r_rr      <= '0;
         r_grant   <= '0;
         r_pending <= '0;
         r_motor   <= '0;
         r_accept  <= 1'b0;
         r_change  <= 1'b0;
         r_deny    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_rise;
         r_accept  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_valid) begin
                  r_grant <= w_gnt_idx;
                  r_rr    <= w_rr_next;
                  r_busy  <= 1'b1;
                  r_state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               r_cr_q <= credit;
               r_pr_q <= w_price;
               if (credit >= w_price) begin
                  r_motor <= N_PROD'(1) << r_grant;
                  r_cnt   <= CNT_W'(MOTOR_CYC);
                  r_state <= ST_VEND;
               end else begin
                  r_deny  <= 1'b1;
                  r_cnt   <= CNT_W'(DENY_CYC);
                  r_state <= ST_DENY;
               end
            end
            ST_VEND: begin
               if (r_cnt == CNT_W'(1)) begin
                  r_motor  <= '0;
                  r_accept <= 1'b1;
                  r_state  <= ST_ACCEPT;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_ACCEPT: begin
               r_chg <= r_cr_q - r_pr_q;
               if (r_cr_q == r_pr_q) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_change <= 1'b1;
                  r_cnt    <= CNT_W'(CHG_CYC);
                  r_state  <= ST_CHG_HI;
               end
            end
            ST_CHG_HI: begin
               if (r_cnt == CNT_W'(1)) begin
                  r_change <= 1'b0;
                  r_chg    <= r_chg - CREDIT_W'(1);
                  r_cnt    <= CNT_W'(CHG_CYC);
                  r_state  <= ST_CHG_LO;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_CHG_LO: begin
               if (r_cnt == CNT_W'(1)) begin
                  if (r_chg != '0) begin
                     r_change <= 1'b1;
                     r_cnt    <= CNT_W'(CHG_CYC);
                     r_state  <= ST_CHG_HI;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_DENY: begin
               if (r_cnt == CNT_W'(1)) begin
                  r_deny  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_motor  <= '0;
               r_change <= 1'b0;
               r_deny   <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef VEND_STATS_EN
   logic [15:0] r_vend_cnt;

   // One count per completed ACCEPT; wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vend_cnt <= '0;
      end else if (r_state == ST_ACCEPT) begin
         r_vend_cnt <= r_vend_cnt + 16'd1;
      end
   end

   assign vend_count = r_vend_cnt;
`else
   assign vend_count = 16'd0;
`endif

   assign accept   = r_accept;
   assign motor    = r_motor;
   assign change   = r_change;
   assign deny     = r_deny;
   assign busy     = r_busy;
   assign grant_id = r_grant;

endmodule
